// File: rtl/modmul_stream.sv
// modmul_stream: multi-lane modular MUL (Barrett) / ADD / SUB stream unit.
//
// Each accepted beat carries lanes_p operand pairs sharing one modulus. The
// beat's modulus, Barrett constant, modulus width, op and tag ride a sideband
// pipeline next to the data. The pipeline is fixed-latency and never stalls.
// Results land in a first-word fall-through FIFO. Input acceptance is
// credit-limited so that the FIFO can never overflow.
//
// Ports
//   clk_i, rst_n      clock, async active-low reset
//   in_valid_i/o_ready input handshake (in_ready_o from registered counts only)
//   op_i              0=MUL 1=ADD 2=SUB(a-b) 3=reserved (zero result, err_o=1)
//   opa_i, opb_i      lane operands, lane i at [i*dw +: dw]
//   mod_i, imod_i     modulus m and floor(2^(2n+1)/m)
//   mod_width_i       n = bit length of m
//   tag_i / tag_o     opaque tag carried with the beat
//   out_valid_o/out_ready_i  output handshake
//   res_o, err_o      lane results, reserved-op flag

// Pipelined W x W multiplier built from (2^(LEVEL-1))^2 chunk products.
// The first stage registers the chunk products. The remaining stages only
// delay the summed product.
module modmul_mul #(
  parameter int W      = 64,
  parameter int LEVEL  = 2,
  parameter int STAGES = 2
) (
  input  logic           clk_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);
  localparam int CH = 1 << (LEVEL - 1);
  localparam int CW = W / CH;

  logic [CH*CH-1:0][2*CW-1:0] pp_q;
  logic [2*W-1:0] sum, ext;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < CH; i++)
      for (int j = 0; j < CH; j++)
        pp_q[i*CH+j] <= {{CW{1'b0}}, a_i[i*CW +: CW]} * {{CW{1'b0}}, b_i[j*CW +: CW]};
  end

  always_comb begin
    sum = '0;
    ext = '0;
    for (int i = 0; i < CH; i++)
      for (int j = 0; j < CH; j++) begin
        ext = '0;
        ext[2*CW-1:0] = pp_q[i*CH+j];
        sum = sum + (ext << ((i + j) * CW));
      end
  end

  if (STAGES == 1) begin : g_s1
    assign p_o = sum;
  end else begin : g_sn
    logic [2*W-1:0] dq [STAGES-1];
    always_ff @(posedge clk_i) begin
      dq[0] <= sum;
      for (int s = 1; s < STAGES - 1; s++) dq[s] <= dq[s-1];
    end
    assign p_o = dq[STAGES-2];
  end
endmodule

// One lane. Operands arrive from the input register at stage 0. The shared
// sideband fields are tapped by the top at the stage where each is used:
//   0 -> M1 (a*b) and add/sub; S -> M2; 2S -> M3; 3S -> r and first correct;
//   3S+1 -> second correct (combinational, feeds FIFO write)
module modmul_lane #(
  parameter int W     = 64,
  parameter int NW    = 6,
  parameter int LEVEL = 2,
  parameter int S     = 2
) (
  input  logic          clk_i,
  input  logic [W-1:0]  a_i,
  input  logic [W-1:0]  b_i,
  input  logic [1:0]    op0_i,
  input  logic [W-1:0]  m0_i,
  input  logic [NW-1:0] n1_i,
  input  logic [W-1:0]  imod1_i,
  input  logic [NW-1:0] n2_i,
  input  logic [W-1:0]  m2_i,
  input  logic [1:0]    op3_i,
  input  logic [NW-1:0] n3_i,
  input  logic [W-1:0]  m3_i,
  input  logic [1:0]    op4_i,
  input  logic [W-1:0]  m4_i,
  output logic [W-1:0]  res_o
);
  localparam logic [1:0] OP_MUL = 2'd0;
  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_RSV = 2'd3;

  logic [W:0]     sum_ab;
  logic [W-1:0]   add_r, sub_r, as_r;
  logic [W-1:0]   as_q [3*S];
  logic [W-1:0]   pl_q [2*S];
  logic [2*W-1:0] p1, p2, p3;
  logic [W-1:0]   x, q, mask, r, c1, c1_q;

  // ADD/SUB resolve immediately and then wait out the multiplier latency.
  always_comb begin
    sum_ab = {1'b0, a_i} + {1'b0, b_i};
    add_r  = (sum_ab >= {1'b0, m0_i}) ? W'(sum_ab - {1'b0, m0_i}) : W'(sum_ab);
    sub_r  = (a_i >= b_i) ? a_i - b_i : a_i - b_i + m0_i;
    as_r   = (op0_i == OP_ADD) ? add_r : sub_r;
  end

  always_ff @(posedge clk_i) begin
    as_q[0] <= as_r;
    for (int j = 1; j < 3*S; j++) as_q[j] <= as_q[j-1];
    pl_q[0] <= p1[W-1:0];
    for (int j = 1; j < 2*S; j++) pl_q[j] <= pl_q[j-1];
  end

  modmul_mul #(.W(W), .LEVEL(LEVEL), .STAGES(S)) u_m1 (.clk_i, .a_i(a_i), .b_i(b_i), .p_o(p1));

  // p < 2^(2n), so p >> (n-2) fits in n+2 <= W bits.
  assign x = W'(p1 >> (n1_i - NW'(2)));
  modmul_mul #(.W(W), .LEVEL(LEVEL), .STAGES(S)) u_m2 (.clk_i, .a_i(x), .b_i(imod1_i), .p_o(p2));

  // n+3 can exceed the n field range, so widen before adding.
  assign q = W'(p2 >> ({1'b0, n2_i} + (NW+1)'(3)));
  modmul_mul #(.W(W), .LEVEL(LEVEL), .STAGES(S)) u_m3 (.clk_i, .a_i(q), .b_i(m2_i), .p_o(p3));

  // The quotient estimate is at most one short, so r < 2m < 2^(n+1). Only the
  // low n+1 bits of p - q*m are therefore needed.
  always_comb begin
    mask = W'(((W+1)'(1) << ({1'b0, n3_i} + (NW+1)'(1))) - (W+1)'(1));
    r    = W'({{W{1'b0}}, pl_q[2*S-1]} - p3) & mask;
    c1   = (r >= m3_i) ? r - m3_i : r;
  end

  always_ff @(posedge clk_i) begin
    if (op3_i == OP_MUL)      c1_q <= c1;
    else if (op3_i == OP_RSV) c1_q <= '0;
    else                      c1_q <= as_q[3*S-1];
  end

  assign res_o = (op4_i == OP_MUL && c1_q >= m4_i) ? c1_q - m4_i : c1_q;
endmodule

module modmul_stream #(
  parameter int data_width_p = 64,
  parameter int lanes_p      = 4,
  parameter int mul_level_p  = 2,
  parameter int mul_stage_p  = 2,
  parameter int fifo_depth_p = 16,
  parameter int tag_width_p  = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_n,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [1:0]                        op_i,
  input  logic [lanes_p*data_width_p-1:0]   opa_i,
  input  logic [lanes_p*data_width_p-1:0]   opb_i,
  input  logic [data_width_p-1:0]           mod_i,
  input  logic [data_width_p-1:0]           imod_i,
  input  logic [$clog2(data_width_p)-1:0]   mod_width_i,
  input  logic [tag_width_p-1:0]            tag_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [lanes_p*data_width_p-1:0]   res_o,
  output logic [tag_width_p-1:0]            tag_o,
  output logic                              err_o
);
  localparam int W   = data_width_p;
  localparam int NW  = $clog2(data_width_p);
  localparam int S   = mul_stage_p;
  localparam int LAT = 3*S + 2;
  localparam int AW  = $clog2(fifo_depth_p);

  typedef struct packed {
    logic [1:0]             op;
    logic [W-1:0]           m;
    logic [W-1:0]           imod;
    logic [NW-1:0]          n;
    logic [tag_width_p-1:0] tag;
  } side_t;

  typedef struct packed {
    logic                         err;
    logic [tag_width_p-1:0]       tag;
    logic [lanes_p-1:0][W-1:0]    res;
  } ent_t;

  logic                      accept, push, pop, full;
  logic [LAT-1:0]            vld_pipe;
  side_t                     side_q [LAT];
  logic [lanes_p-1:0][W-1:0] a_q, b_q, lane_res;
  ent_t                      mem [fifo_depth_p];
  ent_t                      head;
  logic [AW-1:0]             wr_q, rd_q;
  logic [AW:0]               cnt_q, cnt_d, infl_q, infl_d;

  assign accept = in_valid_i & in_ready_o;
  assign push   = vld_pipe[LAT-1];
  assign pop    = out_valid_o & out_ready_i;
  assign full   = (cnt_q == (AW+1)'(fifo_depth_p));

  // Credit check sees only registered counts, so out_ready_i never reaches in_ready_o.
  assign in_ready_o = ({1'b0, infl_q} + {1'b0, cnt_q}) < (AW+2)'(fifo_depth_p);

  always_ff @(posedge clk_i) begin
    if (accept) begin
      a_q       <= opa_i;
      b_q       <= opb_i;
      side_q[0] <= '{op: op_i, m: mod_i, imod: imod_i, n: mod_width_i, tag: tag_i};
    end
    for (int i = 1; i < LAT; i++) side_q[i] <= side_q[i-1];
  end

  modmul_lane #(.W(W), .NW(NW), .LEVEL(mul_level_p), .S(S)) u_lane [lanes_p-1:0] (
    .clk_i   (clk_i),
    .a_i     (a_q),
    .b_i     (b_q),
    .op0_i   (side_q[0].op),
    .m0_i    (side_q[0].m),
    .n1_i    (side_q[S].n),
    .imod1_i (side_q[S].imod),
    .n2_i    (side_q[2*S].n),
    .m2_i    (side_q[2*S].m),
    .op3_i   (side_q[3*S].op),
    .n3_i    (side_q[3*S].n),
    .m3_i    (side_q[3*S].m),
    .op4_i   (side_q[LAT-1].op),
    .m4_i    (side_q[LAT-1].m),
    .res_o   (lane_res)
  );

  always_ff @(posedge clk_i) begin
    if (push)
      mem[wr_q] <= '{err: (side_q[LAT-1].op == 2'd3), tag: side_q[LAT-1].tag, res: lane_res};
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
    infl_d = infl_q;
    if (accept && !push)      infl_d = infl_q + 1'b1;
    else if (push && !accept) infl_d = infl_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      infl_q   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LAT-2:0], accept};
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      cnt_q  <= cnt_d;
      infl_q <= infl_d;
    end
  end

  // Gate the read data so that outputs are all-zero whenever the FIFO is empty.
  assign head        = mem[rd_q];
  assign out_valid_o = (cnt_q != '0);
  assign res_o       = out_valid_o ? head.res : '0;
  assign tag_o       = out_valid_o ? head.tag : '0;
  assign err_o       = out_valid_o & head.err;

  always @(posedge clk_i) begin
    if (rst_n) begin
      assert (!(push && full && !pop));
      assert (!(pop && cnt_q == '0));
    end
  end
endmodule

// File: tb/tb_modmul_stream.sv
module tb_modmul_stream;
  localparam int W = 64, L = 4, NW = 6, TW = 8, DEPTH = 16;

  logic            clk = 0, rst_n = 0;
  logic            in_valid_i = 0, in_ready_o, out_valid_o, out_ready_i = 1, err_o;
  logic [1:0]      op_i = 0;
  logic [L*W-1:0]  opa_i = '0, opb_i = '0, res_o;
  logic [W-1:0]    mod_i = '0, imod_i = '0;
  logic [NW-1:0]   mod_width_i = '0;
  logic [TW-1:0]   tag_i = '0, tag_o;

  always #5 clk = ~clk;

  modmul_stream dut (
    .clk_i(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .opa_i(opa_i), .opb_i(opb_i), .mod_i(mod_i), .imod_i(imod_i),
    .mod_width_i(mod_width_i), .tag_i(tag_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .res_o(res_o), .tag_o(tag_o), .err_o(err_o)
  );

  typedef struct { logic [L*W-1:0] res; logic [TW-1:0] tag; logic err; } exp_t;
  exp_t sb[$];
  exp_t cur, chk;
  int n_assert = 0, n_fail = 0, cyc = 0, pops = 0, first_pop = -1, last_pop = -1;

  always @(posedge clk) cyc++;

  function automatic logic [W-1:0] gold(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] m);
    logic [2*W-1:0] p;
    case (op)
      2'd0: begin p = {64'd0, a} * {64'd0, b}; return W'(p % {64'd0, m}); end
      2'd1: return W'(({1'b0, a} + {1'b0, b}) % {1'b0, m});
      2'd2: return W'(({1'b0, a} + {1'b0, m} - {1'b0, b}) % {1'b0, m});
      default: return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] barrett(int n, logic [W-1:0] m);
    logic [127:0] num;
    num = 128'd1 << (2*n + 1);
    return W'(num / {64'd0, m});
  endfunction

  task automatic load(input logic [1:0] op, input logic [W-1:0] m, input int n, input logic [TW-1:0] tag);
    op_i = op; mod_i = m; imod_i = barrett(n, m); mod_width_i = NW'(n); tag_i = tag;
    in_valid_i = 1;
    cur.tag = tag; cur.err = (op == 2'd3);
    for (int l = 0; l < L; l++) cur.res[l*W +: W] = gold(op, opa_i[l*W +: W], opb_i[l*W +: W], m);
  endtask

  task automatic rand_beat(input logic [TW-1:0] tag, input logic [1:0] op);
    int n;
    logic [W-1:0] m, r;
    n = $urandom_range(2, 62);
    r = {$urandom(), $urandom()};
    m = (r & ((64'd1 << n) - 1)) | (64'd1 << (n - 1));
    for (int l = 0; l < L; l++) begin
      r = {$urandom(), $urandom()}; opa_i[l*W +: W] = r % m;
      r = {$urandom(), $urandom()}; opb_i[l*W +: W] = r % m;
    end
    load(op, m, n, tag);
  endtask

  task automatic step(output bit acc);
    @(negedge clk);
    acc = in_valid_i && in_ready_o;
    if (acc) sb.push_back(cur);
    @(posedge clk); #1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() > 0; i++) @(posedge clk);
    #1;
    n_assert++;
    assert (sb.size() == 0) else begin n_fail++; $error("FAIL drain: %0d beats outstanding, expected 0", sb.size()); end
  endtask

  // Scoreboard: an output beat is consumed at the next edge when valid & ready.
  always @(negedge clk) begin
    if (rst_n && out_valid_o && out_ready_i) begin
      n_assert++;
      assert (sb.size() > 0) else begin n_fail++; $error("FAIL unexpected_beat: got tag=%h, expected no beat", tag_o); end
      if (sb.size() > 0) begin
        chk = sb.pop_front();
        n_assert++;
        assert (res_o === chk.res) else begin n_fail++; $error("FAIL res tag=%h: got %h expected %h", chk.tag, res_o, chk.res); end
        n_assert++;
        assert ({tag_o, err_o} === {chk.tag, chk.err}) else begin
          n_fail++; $error("FAIL tag_err: got tag=%h err=%b expected tag=%h err=%b", tag_o, err_o, chk.tag, chk.err);
        end
        pops++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
    end
  end

  initial begin
    bit acc;
    int stalls, accepted, more, p0, stale;
    logic [W-1:0] m;

    // Reset state
    repeat (3) @(posedge clk); #1;
    n_assert++;
    assert ({out_valid_o, res_o, tag_o, err_o} === '0) else begin
      n_fail++; $error("FAIL reset_out: got v=%b tag=%h err=%b, expected all zero", out_valid_o, tag_o, err_o);
    end
    n_assert++;
    assert (in_ready_o === 1'b1) else begin n_fail++; $error("FAIL reset_ready: got %b expected 1", in_ready_o); end
    rst_n = 1;
    @(posedge clk); #1;

    // Single MUL, latency and value
    m = 64'h1FFF_FFFF_FFFF_FFFF;
    for (int l = 0; l < L; l++) begin opa_i[l*W +: W] = m - 1; opb_i[l*W +: W] = m - 1; end
    load(2'd0, m, 61, 8'h5A);
    step(acc);
    in_valid_i = 0;
    repeat (7) @(posedge clk); #1;
    n_assert++;
    assert (out_valid_o === 1'b0) else begin n_fail++; $error("FAIL lat_early: out_valid got %b expected 0 at k+7", out_valid_o); end
    @(posedge clk); #1;
    n_assert++;
    assert (out_valid_o === 1'b1) else begin n_fail++; $error("FAIL lat_on: out_valid got %b expected 1 at k+8", out_valid_o); end
    n_assert++;
    assert ({res_o, tag_o} === {{L{64'd1}}, 8'h5A}) else begin
      n_fail++; $error("FAIL mul_single: got res=%h tag=%h expected all lanes 1 tag 5a", res_o, tag_o);
    end
    drain(20);

    // ADD then SUB, m=97
    opa_i = {64'd3, 64'd0, 64'd50, 64'd96};
    opb_i = {64'd96, 64'd0, 64'd60, 64'd1};
    load(2'd1, 64'd97, 7, 8'h01);
    step(acc);
    load(2'd2, 64'd97, 7, 8'h02);
    step(acc);
    in_valid_i = 0;
    repeat (7) @(posedge clk); #1;
    n_assert++;
    assert (res_o === {64'd2, 64'd0, 64'd13, 64'd0}) else begin n_fail++; $error("FAIL add97: got %h expected lanes 0,13,0,2", res_o); end
    @(posedge clk); #1;
    n_assert++;
    assert (res_o === {64'd4, 64'd0, 64'd87, 64'd95}) else begin n_fail++; $error("FAIL sub97: got %h expected lanes 95,87,0,4", res_o); end
    drain(20);

    // Reserved op between two MULs
    rand_beat(8'h10, 2'd0); step(acc);
    rand_beat(8'h11, 2'd3); step(acc);
    rand_beat(8'h12, 2'd0); step(acc);
    in_valid_i = 0;
    drain(30);

    // 1000 back-to-back random beats
    first_pop = -1; p0 = pops; stalls = 0;
    for (int i = 0; i < 1000; i++) begin
      rand_beat(TW'(i), 2'($urandom_range(0, 2)));
      step(acc);
      for (int t = 0; t < 20 && !acc; t++) begin stalls++; step(acc); end
    end
    in_valid_i = 0;
    drain(200);
    n_assert++;
    assert (stalls == 0) else begin n_fail++; $error("FAIL stream_stalls: got %0d expected 0", stalls); end
    n_assert++;
    assert (pops - p0 == 1000 && last_pop - first_pop == 999) else begin
      n_fail++; $error("FAIL stream_rate: got %0d beats over %0d cycles, expected 1000 over 999", pops - p0, last_pop - first_pop);
    end

    // Backpressure: credits cap acceptance at DEPTH
    out_ready_i = 0; accepted = 0; p0 = pops;
    rand_beat(8'h80, 2'($urandom_range(0, 2)));
    for (int c = 0; c < 40; c++) begin
      step(acc);
      if (acc) begin accepted++; rand_beat(TW'(8'h80 + accepted), 2'($urandom_range(0, 2))); end
    end
    n_assert++;
    assert (accepted == DEPTH) else begin n_fail++; $error("FAIL bp_accepted: got %0d expected %0d", accepted, DEPTH); end
    n_assert++;
    assert (in_ready_o === 1'b0) else begin n_fail++; $error("FAIL bp_ready: got %b expected 0", in_ready_o); end
    out_ready_i = 1; more = 0;
    for (int c = 0; c < 200 && more < 16; c++) begin
      step(acc);
      if (acc) begin more++; if (more < 16) rand_beat(TW'(8'hA0 + more), 2'($urandom_range(0, 2))); end
    end
    in_valid_i = 0;
    drain(100);
    n_assert++;
    assert (pops - p0 == 32) else begin n_fail++; $error("FAIL bp_count: got %0d results expected 32", pops - p0); end

    // Async reset with 5 in flight and 3 buffered
    out_ready_i = 0;
    for (int i = 0; i < 8; i++) begin rand_beat(TW'(8'hC0 + i), 2'd0); step(acc); end
    in_valid_i = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 0;
    #1;
    n_assert++;
    assert ({out_valid_o, res_o, tag_o, err_o} === '0) else begin
      n_fail++; $error("FAIL rst_out: got v=%b tag=%h err=%b expected all zero", out_valid_o, tag_o, err_o);
    end
    n_assert++;
    assert (in_ready_o === 1'b1) else begin n_fail++; $error("FAIL rst_ready: got %b expected 1", in_ready_o); end
    sb.delete();
    #3 rst_n = 1;
    out_ready_i = 1; stale = 0;
    for (int c = 0; c < 30; c++) begin @(posedge clk); #1; if (out_valid_o) stale++; end
    n_assert++;
    assert (stale == 0) else begin n_fail++; $error("FAIL stale: got %0d stale cycles expected 0", stale); end
    rand_beat(8'hEE, 2'd0); step(acc);
    in_valid_i = 0;
    drain(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/modmul_stream.md
Name: modmul_stream

Overview:
- Multi-lane modular arithmetic unit for the VP vector unit.
- Performs modular multiply (Barrett reduction), add or subtract on lanes_p operand pairs per beat, with all lanes sharing one modulus.
- Full valid/ready handshake on both sides; an internal credit-controlled output FIFO absorbs downstream stalls without stalling the multiplier pipeline.
- An opaque tag travels with each beat so vector-issue logic can match results to requests.

Parameters:
- data_width_p, 64, operand/modulus width.
- lanes_p, 4, parallel lanes per beat (1..8).
- mul_level_p, 2, decomposition level of each internal 64-bit multiplier (1/2/3).
- mul_stage_p, 2, pipeline stages per internal multiplier (>=1).
- fifo_depth_p, 16, output FIFO entries; must be >= L (defined below), power of two.
- tag_width_p, 8, tag width.

Ports:
- clk_i, in, 1, clock.
- rst_n, in, 1, reset: asynchronous, active-low.
- in_valid_i, in, 1, input beat valid.
- in_ready_o, out, 1, input beat accepted when in_valid_i & in_ready_o.
- op_i, in, 2, 0=MUL, 1=ADD, 2=SUB (a-b), 3=reserved.
- opa_i, in, lanes_p*data_width_p, lane operands A; lane i in bits [i*dw +: dw].
- opb_i, in, lanes_p*data_width_p, lane operands B.
- mod_i, in, data_width_p, modulus m, shared by all lanes.
- imod_i, in, data_width_p, Barrett constant floor(2^(2n+1)/m).
- mod_width_i, in, $clog2(data_width_p), n = bit length of m; 2 <= n <= data_width_p-2.
- tag_i, in, tag_width_p, opaque tag.
- out_valid_o, out, 1, result beat valid.
- out_ready_i, in, 1, downstream accepts a beat.
- res_o, out, lanes_p*data_width_p, lane results.
- tag_o, out, tag_width_p, tag of the beat on res_o.
- err_o, out, 1, beat was issued with op_i=3; res_o lanes are zero.

Behaviour:
- Reset: every output is 0 except in_ready_o, which is 1. The FIFO is empty, credit count is 0, and pipeline valids are 0.
- Reset asserted mid-operation discards all in-flight and buffered beats. No partial output may appear after rst_n deasserts.
- Pipeline latency L = 3*mul_stage_p + 2 register stages, identical for every op so that beats stay in order.
- MUL per lane:
  - p = a*b (2*dw bits); q = ((p >> (n-2)) * imod) >> (n+3).
  - r = (p - q*m) mod 2^(n+1).
  - Correction stage: two cascaded conditional subtracts of m. Result is exactly (a*b) mod m.
- ADD/SUB per lane:
  - Bypass the multipliers through delay registers.
  - ADD: s = a+b (dw+1 bits); if s >= m then s - m.
  - SUB: if a >= b then a - b, else a - b + m.
- Operand precondition: a, b < m. Behaviour is undefined otherwise, and the bench must not drive it.
- op_i=3: beat flows normally with zero results and err_o=1 on that output beat only.
- mod_i, imod_i, mod_width_i and op_i are captured per beat at accept and pipelined alongside the data, so consecutive beats may use different moduli.
- Pipeline advances every cycle; it never stalls.
- Credit rule: in_ready_o = (inflight + fifo_count) < fifo_depth_p, computed from registered counts only; no combinational path from out_ready_i.
  - inflight increments on accept and decrements on FIFO write.
  - If accept and FIFO write occur in the same cycle, inflight is unchanged.
- FIFO is first-word fall-through:
  - out_valid_o = !empty; res_o, tag_o and err_o are valid while out_valid_o is high.
  - A pop occurs on out_valid_o & out_ready_i.
  - Read and write pointers wrap modulo fifo_depth_p.
  - Simultaneous push and pop with a full FIFO is legal and leaves the count unchanged.
  - Push into an empty FIFO: out_valid_o is high in the cycle after the write edge.
- Overflow is impossible by the credit rule. The implementation must carry assertions for no push when full and no pop when empty.
- Input accepted on edge k with FIFO empty: out_valid_o is high in the cycle after edge k+L.
- Sustained throughput is 1 beat/cycle while out_ready_i=1.

Test Plan:
- MUL, single beat, m=0xFFFFFFFF00000001 (n=64 is invalid, so use m=2^61-1, n=61), a=m-1, b=m-1, tag=0x5A -> res=1 in every lane, tag_o=0x5A, out_valid_o 1 cycle after edge k+8 (mul_stage_p=2).
- ADD/SUB, m=97, lanes (a,b)=(96,1),(50,60),(0,0),(3,96) -> ADD {0,13,0,2}; SUB on the same operands -> {95,87,0,4}.
- Back-to-back 1000 random MUL/ADD/SUB beats with random moduli per beat (n from 2 to 62), out_ready_i=1 -> all results match the golden model, in order, 1 beat/cycle.
- out_ready_i=0 for 40 cycles under continuous in_valid_i -> exactly fifo_depth_p=16 beats accepted, then in_ready_o=0. Release out_ready_i -> 16 in-order results, then acceptance resumes with no loss or duplication.
- op_i=3 beat between two MUL beats -> middle output has err_o=1 and res=0; neighbouring beats are correct with err_o=0.
- rst_n pulsed low asynchronously (mid-cycle) with 5 beats in flight and 3 buffered -> outputs zero immediately, in_ready_o=1 after release, and no stale beat ever emerges.
